cmd_phys: RTL

CMD_PHYS -- requirements
Module: cmd_phys

---
 rtl/cmd_phys.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cmd_phys.sv
// SD command-line PHY: serializes a 48-bit command frame with CRC7, then
// waits for and deserializes the card's 48-bit response, checking framing/CRC7.
module cmd_phys #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iStrobe_in,
  input  logic [37:0] iCmd_in,
  input  logic        iAck_in,
  input  logic        iCmd_pin_in,
  output logic        oAck_out,
  output logic        oStrobe_out,
  output logic [37:0] oCmd_out,
  output logic        oCmd_pin_out,
  output logic        oCmd_pin_oe,
  output logic        oTimeout_enable,
  output logic        oTimeout,
  output logic        oCrc_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = (TW > 6) ? TW : 6;

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_RESP, RECEIVE, CHECK, RESPOND
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [47:0] sh_q, sh_d;
  logic [47:0] rx_q, rx_d;
  logic [47:0] frame;
  logic [37:0] cmd_out_q, cmd_out_d;
  logic        ack_q, ack_d;
  logic        strobe_q, strobe_d;
  logic        pin_out_q, pin_out_d;
  logic        pin_oe_q, pin_oe_d;
  logic        ten_q, ten_d;
  logic        timeout_q, timeout_d;
  logic        crc_err_q, crc_err_d;

  // x^7 + x^3 + 1, zero seed, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign frame = {2'b01, iCmd_in, crc7({2'b01, iCmd_in}), 1'b1};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    cmd_out_d = cmd_out_q;
    ack_d     = 1'b0;
    strobe_d  = strobe_q;
    pin_out_d = pin_out_q;
    pin_oe_d  = pin_oe_q;
    ten_d     = ten_q;
    timeout_d = 1'b0;
    crc_err_d = crc_err_q;
    case (state_q)
      IDLE: begin
        pin_out_d = 1'b1;
        pin_oe_d  = 1'b1;
        if (iStrobe_in) begin
          // Bit 47 goes on the line in the same cycle as the ack pulse.
          pin_out_d = frame[47];
          sh_d      = {frame[46:0], 1'b0};
          ack_d     = 1'b1;
          cnt_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (cnt_q == CW'(47)) begin
          pin_out_d = 1'b1;
          pin_oe_d  = 1'b0;
          ten_d     = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_RESP;
        end else begin
          pin_out_d = sh_q[47];
          sh_d      = {sh_q[46:0], 1'b0};
          cnt_d     = cnt_q + 1'b1;
        end
      end
      WAIT_RESP: begin
        // Start bit takes priority over an expiring timeout.
        if (!iCmd_pin_in) begin
          rx_d    = {47'd0, iCmd_pin_in};
          cnt_d   = '0;
          state_d = RECEIVE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          ten_d     = 1'b0;
          pin_out_d = 1'b1;
          pin_oe_d  = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECEIVE: begin
        rx_d = {rx_q[46:0], iCmd_pin_in};
        if (cnt_q == CW'(46)) begin
          ten_d   = 1'b0;
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        crc_err_d = rx_q[46] | ~rx_q[0] | (rx_q[7:1] != crc7(rx_q[47:8]));
        cmd_out_d = rx_q[45:8];
        strobe_d  = 1'b1;
        pin_out_d = 1'b1;
        pin_oe_d  = 1'b1;
        state_d   = RESPOND;
      end
      RESPOND: begin
        if (iAck_in) begin
          strobe_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock_host) begin
    if (iReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      cmd_out_q <= '0;
      ack_q     <= 1'b0;
      strobe_q  <= 1'b0;
      pin_out_q <= 1'b1;
      pin_oe_q  <= 1'b1;
      ten_q     <= 1'b0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      cmd_out_q <= cmd_out_d;
      ack_q     <= ack_d;
      strobe_q  <= strobe_d;
      pin_out_q <= pin_out_d;
      pin_oe_q  <= pin_oe_d;
      ten_q     <= ten_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign oAck_out        = ack_q;
  assign oStrobe_out     = strobe_q;
  assign oCmd_out        = cmd_out_q;
  assign oCmd_pin_out    = pin_out_q;
  assign oCmd_pin_oe     = pin_oe_q;
  assign oTimeout_enable = ten_q;
  assign oTimeout        = timeout_q;
  assign oCrc_error      = crc_err_q;

endmodule
